// File: rtl/fpu_arb_pkg.sv
// rtl/fpu_arb_pkg.sv - shared opcodes, state encoding and word width for fpu_arb
//
// Purpose : constants and types used by fpu_arb and its round-robin picker.
// Contents: WORD data width, FPU opcodes OPADDF..OPSUBF, farb_state_t,
//           is_valid_op() opcode range check.
package fpu_arb_pkg;

   localparam int WORD = 16;

   localparam logic [4:0] OPADDF = 5'h11;
   localparam logic [4:0] OPFTOI = 5'h12;
   localparam logic [4:0] OPITOF = 5'h13;
   localparam logic [4:0] OPMULF = 5'h14;
   localparam logic [4:0] OPRECF = 5'h15;
   localparam logic [4:0] OPSUBF = 5'h16;

   typedef enum logic [1:0] {
      FARB_IDLE  = 2'd0,
      FARB_ISSUE = 2'd1,
      FARB_WAIT  = 2'd2,
      FARB_RESP  = 2'd3
   } farb_state_t;

   // The FPU opcodes form one contiguous range.
   function automatic logic is_valid_op(input logic [4:0] op);
      return (op >= OPADDF) && (op <= OPSUBF);
   endfunction

endpackage

// File: rtl/fpu_arb_rr_pick2.sv
// rtl/fpu_arb_rr_pick2.sv - combinational two-way round-robin picker
//
// Purpose: picks one of two requesters; under contention the one that is
//          not ptr wins, so ptr holds the most recently granted id.
// Ports  : req0, req1 - request lines
//          ptr        - id of the last grant
//          gnt        - at least one request present
//          id         - winning requester (meaningful only with gnt)
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic ptr,
   output logic gnt,
   output logic id
);

   assign gnt = req0 | req1;
   assign id  = (req0 & req1) ? ~ptr : req1;

endmodule

// File: rtl/fpu_arb.sv
// rtl/fpu_arb.sv - two-port round-robin sequencer sharing one multicycle FPU
//
// Purpose: grants one of two requesters, drives the FPU with the latched
//          opcode/operands, waits for done (bounded by TIMEOUT) and returns
//          the result with a one-cycle ack to the granted requester.
// Ports  : clk, rst_n                  - clock, async active-low reset
//          req0/instr0/opa0/opb0       - requester 0 (held until ack0)
//          req1/instr1/opa1/opb1       - requester 1 (held until ack1)
//          ack0, ack1                  - one-cycle result-valid pulses
//          res, err                    - result word and error flag, valid with ack
//          fpu_en/instr/op1/op2        - to the FPU
//          fpu_result, fpu_done        - from the FPU
module fpu_arb
   import fpu_arb_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int FIRST   = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req0,
   input  logic [4:0]      instr0,
   input  logic [WORD-1:0] opa0,
   input  logic [WORD-1:0] opb0,
   input  logic            req1,
   input  logic [4:0]      instr1,
   input  logic [WORD-1:0] opa1,
   input  logic [WORD-1:0] opb1,
   output logic            ack0,
   output logic            ack1,
   output logic [WORD-1:0] res,
   output logic            err,
   output logic            fpu_en,
   output logic [4:0]      fpu_instr,
   output logic [WORD-1:0] fpu_op1,
   output logic [WORD-1:0] fpu_op2,
   input  logic [WORD-1:0] fpu_result,
   input  logic            fpu_done
);

   localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT - 1);
   localparam logic       PTR_RESET = 1'(FIRST);

   farb_state_t     state, state_n;
   logic [7:0]      cnt, cnt_n;
   logic            ptr, ptr_n;
   logic            id_q, id_n;
   logic [4:0]      instr_q, instr_n;
   logic [WORD-1:0] opa_q, opa_n;
   logic [WORD-1:0] opb_q, opb_n;
   logic [WORD-1:0] res_q, res_n;
   logic            err_q, err_n;

   logic            pick_gnt;
   logic            pick_id;
   logic [4:0]      pick_instr;

   rr_pick2 u_pick (
      .req0 (req0),
      .req1 (req1),
      .ptr  (ptr),
      .gnt  (pick_gnt),
      .id   (pick_id)
   );

   assign pick_instr = pick_id ? instr1 : instr0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= FARB_IDLE;
         cnt     <= '0;
         ptr     <= PTR_RESET;
         id_q    <= 1'b0;
         instr_q <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         ptr     <= ptr_n;
         id_q    <= id_n;
         instr_q <= instr_n;
         opa_q   <= opa_n;
         opb_q   <= opb_n;
         res_q   <= res_n;
         err_q   <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ptr_n   = ptr;
      id_n    = id_q;
      instr_n = instr_q;
      opa_n   = opa_q;
      opb_n   = opb_q;
      res_n   = res_q;
      err_n   = err_q;

      unique case (state)
         FARB_IDLE: begin
            if (pick_gnt) begin
               id_n    = pick_id;
               ptr_n   = pick_id;
               instr_n = pick_instr;
               opa_n   = pick_id ? opa1 : opa0;
               opb_n   = pick_id ? opb1 : opb0;
               if (is_valid_op(pick_instr)) begin
                  state_n = FARB_ISSUE;
               end else begin
                  // Bad opcode never reaches the FPU.
                  res_n   = '0;
                  err_n   = 1'b1;
                  state_n = FARB_RESP;
               end
            end
         end
         FARB_ISSUE: begin
            // fpu_done still reflects the previous op here; it is not looked at.
            cnt_n   = '0;
            state_n = FARB_WAIT;
         end
         FARB_WAIT: begin
            cnt_n = cnt + 8'd1;
            if (fpu_done) begin
               // A done arriving on the last allowed cycle still counts.
               res_n   = fpu_result;
               err_n   = 1'b0;
               state_n = FARB_RESP;
            end else if (cnt == CNT_LAST) begin
               res_n   = '0;
               err_n   = 1'b1;
               state_n = FARB_RESP;
            end
         end
         FARB_RESP: begin
            // Requests are deliberately not sampled so the acked side can drop req.
            state_n = FARB_IDLE;
         end
         default: state_n = FARB_IDLE;
      endcase
   end

   assign fpu_en    = (state == FARB_ISSUE) || (state == FARB_WAIT);
   assign fpu_instr = instr_q;
   assign fpu_op1   = opa_q;
   assign fpu_op2   = opb_q;

   assign ack0 = (state == FARB_RESP) && !id_q;
   assign ack1 = (state == FARB_RESP) &&  id_q;
   assign res  = (state == FARB_RESP) ? res_q : '0;
   assign err  = (state == FARB_RESP) && err_q;

endmodule

// File: tb/tb_fpu_arb.sv
// tb/tb_fpu_arb.sv - self-checking bench for fpu_arb with a behavioural bfloat16 FPU
module tb_fpu_arb;
   import fpu_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req1;
   logic [4:0]  instr0, instr1;
   logic [15:0] opa0, opb0, opa1, opb1;
   logic        ack0, ack1;
   logic [15:0] res;
   logic        err;
   logic        fpu_en;
   logic [4:0]  fpu_instr;
   logic [15:0] fpu_op1, fpu_op2;
   logic [15:0] fpu_result;
   logic        fpu_done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fpu_arb #(.TIMEOUT(8), .FIRST(0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0       (req0),
      .instr0     (instr0),
      .opa0       (opa0),
      .opb0       (opb0),
      .req1       (req1),
      .instr1     (instr1),
      .opa1       (opa1),
      .opb1       (opb1),
      .ack0       (ack0),
      .ack1       (ack1),
      .res        (res),
      .err        (err),
      .fpu_en     (fpu_en),
      .fpu_instr  (fpu_instr),
      .fpu_op1    (fpu_op1),
      .fpu_op2    (fpu_op2),
      .fpu_result (fpu_result),
      .fpu_done   (fpu_done)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural FPU (bfloat16) ----------------
   function automatic logic [15:0] bf_itof(input logic [15:0] n);
      int p;
      logic [15:0] m;
      if (n == 16'd0) return 16'h0000;
      p = 0;
      for (int i = 0; i < 16; i++) if (n[i]) p = i;
      m = (p >= 7) ? (n >> (p - 7)) : (n << (7 - p));
      return {1'b0, 8'(127 + p), m[6:0]};
   endfunction

   function automatic logic [15:0] bf_mulf(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] prod;
      int e;
      logic [6:0] m;
      prod = {8'd0, 1'b1, a[6:0]} * {8'd0, 1'b1, b[6:0]};
      e = int'(a[14:7]) + int'(b[14:7]) - 127;
      if (prod[15]) begin
         m = prod[14:8];
         e++;
      end else begin
         m = prod[13:7];
      end
      return {a[15] ^ b[15], 8'(e), m};
   endfunction

   function automatic logic [15:0] fpu_model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
      if (op == OPITOF) return bf_itof(b);
      if (op == OPMULF) return bf_mulf(a, b);
      return a ^ b;
   endfunction

   int   fpu_lat = 3;
   bit   stuck   = 1'b0;
   logic en_q, busy;
   int   cnt_f;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fpu_done   <= 1'b0;
         fpu_result <= '0;
         en_q       <= 1'b0;
         busy       <= 1'b0;
         cnt_f      <= 0;
      end else begin
         en_q <= fpu_en;
         if (fpu_en && !en_q) begin
            fpu_done <= 1'b0;
            busy     <= 1'b1;
            cnt_f    <= fpu_lat - 1;
         end else if (busy && fpu_en) begin
            if (cnt_f == 0) begin
               busy <= 1'b0;
               if (!stuck) begin
                  fpu_done   <= 1'b1;
                  fpu_result <= fpu_model(fpu_instr, fpu_op1, fpu_op2);
               end
            end else begin
               cnt_f <= cnt_f - 1;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct { logic [15:0] res; logic err; } exp_t;
   exp_t q0[$];
   exp_t q1[$];
   bit   en_seen;

   always @(negedge clk) begin
      exp_t e;
      if (fpu_en) en_seen = 1'b1;
      if (ack0 && ack1) check("ack_exclusive", 1, 0);
      if (ack0) begin
         if (q0.size() == 0) check("unexpected_ack0", 1, 0);
         else begin
            e = q0.pop_front();
            check("res0", res, e.res);
            check("err0", err, e.err);
         end
      end
      if (ack1) begin
         if (q1.size() == 0) check("unexpected_ack1", 1, 0);
         else begin
            e = q1.pop_front();
            check("res1", res, e.res);
            check("err1", err, e.err);
         end
      end
   end

   bit model_ptr = 1'b0;

   task automatic push_exp(input bit id, input logic [15:0] r, input logic e);
      exp_t x;
      x.res = r;
      x.err = e;
      if (id) q1.push_back(x);
      else    q0.push_back(x);
   endtask

   task automatic run_op(input bit id, input logic [4:0] op, input logic [15:0] a,
                         input logic [15:0] b, input int lat, input logic [15:0] r,
                         input logic e, output int edges);
      bit got;
      fpu_lat = lat;
      push_exp(id, r, e);
      @(negedge clk);
      if (id) begin req1 = 1; instr1 = op; opa1 = a; opb1 = b; end
      else    begin req0 = 1; instr0 = op; opa0 = a; opb0 = b; end
      got   = 0;
      edges = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if ((id && ack1) || (!id && ack0)) begin
            got   = 1;
            edges = i + 1;
            break;
         end
      end
      if (!got) check("ack_wait_bound", 0, 1);
      req0 = 0;
      req1 = 0;
      model_ptr = id;
      @(negedge clk);
      check("en_low_after_ack", fpu_en, 0);
   endtask

   typedef struct {
      bit          id;
      logic [4:0]  op;
      logic [15:0] a, b;
      int          lat;
      logic [15:0] r;
      logic        e;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int   edges;
      int   acks;
      bit   order[4];
      bit   first;
      bit   got;

      vecs[0] = '{0, OPITOF, 16'h0000, 16'h0005, 3, 16'h40A0, 0};
      vecs[1] = '{1, OPMULF, 16'h4000, 16'h4040, 3, 16'h40C0, 0};
      vecs[2] = '{0, OPMULF, 16'h3F80, 16'h4040, 1, 16'h4040, 0};
      vecs[3] = '{1, OPITOF, 16'h0000, 16'h0008, 5, 16'h4100, 0};
      vecs[4] = '{0, OPADDF, 16'h1234, 16'h00FF, 2, 16'h12CB, 0};
      vecs[5] = '{1, OPSUBF, 16'h0F0F, 16'h00F0, 2, 16'h0FFF, 0};
      vecs[6] = '{0, OPITOF, 16'h0000, 16'h0004, 7, 16'h4080, 0};
      vecs[7] = '{1, OPITOF, 16'h0000, 16'h0006, 8, 16'h0000, 1};
      vecs[8] = '{0, 5'h10,  16'h1111, 16'h2222, 3, 16'h0000, 1};
      vecs[9] = '{1, 5'h17,  16'h3333, 16'h4444, 3, 16'h0000, 1};

      rst_n = 0;
      req0 = 0; req1 = 0;
      instr0 = '0; instr1 = '0;
      opa0 = '0; opb0 = '0; opa1 = '0; opb1 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {ack0, ack1, res, err, fpu_en, fpu_instr, fpu_op1, fpu_op2}, 64'd0);
      rst_n = 1;

      foreach (vecs[k])
         run_op(vecs[k].id, vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].lat, vecs[k].r, vecs[k].e, edges);

      // Invalid opcode: answered right after the grant edge, FPU untouched.
      en_seen = 0;
      run_op(0, 5'h08, 16'h0001, 16'h0002, 3, 16'h0000, 1, edges);
      check("bad_op_latency", edges, 1);
      check("bad_op_fpu_en", en_seen, 0);

      // Constant contention: requesters alternate, stale done never acks early.
      fpu_lat = 2;
      first   = ~model_ptr;
      push_exp(0, 16'h3F80, 0); push_exp(0, 16'h3F80, 0);
      push_exp(1, 16'h4000, 0); push_exp(1, 16'h4000, 0);
      @(negedge clk);
      req0 = 1; instr0 = OPITOF; opa0 = 0; opb0 = 16'd1;
      req1 = 1; instr1 = OPITOF; opa1 = 0; opb1 = 16'd2;
      acks = 0;
      for (int i = 0; i < 200 && acks < 4; i++) begin
         @(negedge clk);
         if (ack0 || ack1) begin
            order[acks] = ack1;
            acks++;
         end
      end
      req0 = 0;
      req1 = 0;
      check("contention_acks", acks, 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("rr_order%0d", i), order[i], first ^ i[0]);
      model_ptr = order[3];
      repeat (3) @(negedge clk);

      // Hung FPU: timeout aborts, then normal service resumes.
      stuck = 1;
      run_op(0, OPITOF, 16'h0000, 16'h0005, 3, 16'h0000, 1, edges);
      check("timeout_latency", edges, 10);
      stuck = 0;
      run_op(0, OPITOF, 16'h0000, 16'h0003, 3, 16'h4040, 0, edges);

      // Asynchronous reset in the middle of WAIT.
      fpu_lat = 20;
      @(negedge clk);
      req0 = 1; instr0 = OPITOF; opa0 = 0; opb0 = 16'd7;
      repeat (5) @(negedge clk);
      check("mid_wait_en", fpu_en, 1);
      #2 rst_n = 0;
      #1 check("async_reset_outputs", {ack0, ack1, res, err, fpu_en, fpu_instr, fpu_op1, fpu_op2}, 64'd0);
      req0 = 0;
      @(negedge clk);
      rst_n = 1;
      model_ptr = 0;
      run_op(1, OPITOF, 16'h0000, 16'h0009, 3, 16'h4110, 0, edges);

      // Both requesting right after reset-equivalent ptr state: ptr=1 now, so 0 wins.
      fpu_lat = 2;
      push_exp(0, 16'h4100, 0);
      @(negedge clk);
      req0 = 1; instr0 = OPITOF; opa0 = 0; opb0 = 16'd8;
      req1 = 1; instr1 = OPMULF; opa1 = 16'h4000; opb1 = 16'h4000;
      got = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ack0 || ack1) begin
            got = 1;
            check("post_reset_rr_winner", ack1, 0);
            break;
         end
      end
      if (!got) check("post_reset_rr_bound", 0, 1);
      req0 = 0;
      req1 = 0;
      repeat (3) @(negedge clk);

      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
